// File: rtl/tt_vec_ldst_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_vec_ldst_seq_pkg                                              |
// | Shared sizes, FSM states and beat format for the vector LD/ST    |
// | sequencer.                                                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package tt_vec_ldst_seq_pkg;

  localparam int VLEN          = 256;
  localparam int ADDRWIDTH     = 40;
  localparam int LQ_DEPTH_LOG2 = 3;
  localparam int BEAT_BYTES    = 16;

  localparam int VLEN_BYTES    = VLEN / 8;
  localparam int VL_W          = $clog2(VLEN + 1);
  localparam int OFF_W         = 12;
  localparam int IDX_W         = $clog2(VLEN_BYTES);
  localparam int BEAT_LO_W     = $clog2(BEAT_BYTES);
  localparam int MAX_BYTES     = 8 * VLEN_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VRD   = 2'd1,
    ST_ISSUE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [LQ_DEPTH_LOG2-1:0] lqid;
    logic [ADDRWIDTH-1:0]     addr;
    logic                     store;
    logic [4:0]               vreg;
    logic [IDX_W-1:0]         idx;
    logic [VLEN_BYTES-1:0]    byte_mask;
    logic                     idx_last;
    logic                     is_128;
    logic [VLEN-1:0]          store_data;
  } vec_ldst_beat_s;

  function automatic logic [3:0] eew_bytes(input logic [1:0] eew);
    return 4'd1 << eew;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_vec_ldst_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_vec_ldst_seq_if                                               |
// | Request, VRF read and memory-beat signals of the sequencer.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface tt_vec_ldst_seq_if;
  import tt_vec_ldst_seq_pkg::*;

  logic                     i_req_vld;
  logic                     o_req_rdy;
  logic                     i_req_store;
  logic                     i_req_strided;
  logic [ADDRWIDTH-1:0]     i_req_base;
  logic [31:0]              i_req_stride;
  logic [1:0]               i_req_eew;
  logic [VL_W-1:0]          i_req_vl;
  logic [4:0]               i_req_vreg;
  logic [LQ_DEPTH_LOG2-1:0] i_req_lqid;
  logic                     i_flush;
  logic [4:0]               o_vrf_raddr;
  logic [VLEN-1:0]          i_vrf_rdata;
  logic                     o_mem_vld;
  logic                     i_mem_rdy;
  vec_ldst_beat_s           o_mem_beat;
  logic                     o_done;
  logic                     o_vl_zero;
  logic                     o_exc_misalign;
  logic                     o_exc_illegal;

  // Sequencer side
  modport slave (
    input  i_req_vld, i_req_store, i_req_strided, i_req_base, i_req_stride,
           i_req_eew, i_req_vl, i_req_vreg, i_req_lqid, i_flush,
           i_vrf_rdata, i_mem_rdy,
    output o_req_rdy, o_vrf_raddr, o_mem_vld, o_mem_beat, o_done, o_vl_zero,
           o_exc_misalign, o_exc_illegal
  );

  // Issue / VRF / LSU side
  modport master (
    output i_req_vld, i_req_store, i_req_strided, i_req_base, i_req_stride,
           i_req_eew, i_req_vl, i_req_vreg, i_req_lqid, i_flush,
           i_vrf_rdata, i_mem_rdy,
    input  o_req_rdy, o_vrf_raddr, o_mem_vld, o_mem_beat, o_done, o_vl_zero,
           o_exc_misalign, o_exc_illegal
  );

endinterface
`default_nettype wire

// File: rtl/tt_vec_ldst_seq_beat_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_vec_ldst_seq_beat_calc                                        |
// | Size, register byte mask and last flag of one memory beat.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tt_vec_ldst_seq_beat_calc
  import tt_vec_ldst_seq_pkg::*;
(
  input  logic [BEAT_LO_W-1:0]  i_addr_lo,
  input  logic [OFF_W-1:0]      i_off,
  input  logic [OFF_W-1:0]      i_total,
  input  logic [1:0]            i_eew,
  input  logic                  i_strided,
  output logic [4:0]            o_n,
  output logic [VLEN_BYTES-1:0] o_byte_mask,
  output logic                  o_last
);

  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_to_beat;
  logic [OFF_W-1:0] w_to_reg;
  logic [OFF_W-1:0] w_left;
  logic [OFF_W-1:0] w_n;

  always_comb begin
    w_idx     = i_off[IDX_W-1:0];
    w_to_beat = OFF_W'(BEAT_BYTES) - {{(OFF_W-BEAT_LO_W){1'b0}}, i_addr_lo};
    w_to_reg  = OFF_W'(VLEN_BYTES) - {{(OFF_W-IDX_W){1'b0}}, w_idx};
    w_left    = i_total - i_off;

    // Unit-stride beats stop at the 16B line, the register end or the data end
    w_n = w_to_beat;
    if (w_to_reg < w_n) w_n = w_to_reg;
    if (w_left < w_n)   w_n = w_left;
    if (i_strided)      w_n = {8'b0, eew_bytes(i_eew)};

    o_n         = w_n[4:0];
    o_byte_mask = ((VLEN_BYTES'(1) << o_n) - VLEN_BYTES'(1)) << w_idx;
    o_last      = (i_off + w_n) == i_total;
  end

endmodule
`default_nettype wire

// File: rtl/tt_vec_ldst_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_vec_ldst_seq                                                  |
// | Splits one vector load/store into memory beats.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tt_vec_ldst_seq
  import tt_vec_ldst_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  tt_vec_ldst_seq_if.slave  bus
);

  seq_state_e               r_state;
  logic [ADDRWIDTH-1:0]     r_addr;
  logic [OFF_W-1:0]         r_off;
  logic [OFF_W-1:0]         r_total;
  logic [4:0]               r_n;
  logic [31:0]              r_stride;
  logic [1:0]               r_eew;
  logic                     r_strided;
  logic                     r_store;
  logic [4:0]               r_vreg0;
  logic [LQ_DEPTH_LOG2-1:0] r_lqid;
  logic                     r_req_rdy;
  logic                     r_mem_vld;
  logic                     r_done;
  logic                     r_vl_zero;
  logic                     r_exc_misalign;
  logic                     r_exc_illegal;
  logic [4:0]               r_vrf_raddr;
  vec_ldst_beat_s           r_beat;

  logic                     w_accept_req;
  logic                     w_beat_acc;
  logic [OFF_W-1:0]         w_req_total;
  logic [2:0]               w_amask;
  logic                     w_misalign;
  logic                     w_illegal;
  logic [ADDRWIDTH-1:0]     w_nxt_addr;
  logic [OFF_W-1:0]         w_nxt_off;
  logic [ADDRWIDTH-1:0]     w_c_addr;
  logic [OFF_W-1:0]         w_c_off;
  logic [OFF_W-1:0]         w_c_total;
  logic [1:0]               w_c_eew;
  logic                     w_c_strided;
  logic [4:0]               w_calc_n;
  logic [VLEN_BYTES-1:0]    w_calc_mask;
  logic                     w_calc_last;
  vec_ldst_beat_s           w_beat;

  assign w_accept_req = bus.i_req_vld & r_req_rdy & ~bus.i_flush;
  assign w_beat_acc   = r_mem_vld & bus.i_mem_rdy;
  assign w_req_total  = {{(OFF_W-VL_W){1'b0}}, bus.i_req_vl} << bus.i_req_eew;
  assign w_amask      = ~(3'b111 << bus.i_req_eew);
  assign w_misalign   = bus.i_req_strided &
                        ((|(bus.i_req_base[2:0] & w_amask)) | (|(bus.i_req_stride[2:0] & w_amask)));
  assign w_illegal    = w_req_total > OFF_W'(MAX_BYTES);

  assign w_nxt_off  = r_off + {{(OFF_W-5){1'b0}}, r_n};
  assign w_nxt_addr = r_strided ? r_addr + {{(ADDRWIDTH-32){r_stride[31]}}, r_stride}
                                : r_addr + ADDRWIDTH'(r_n);

  // Position of the beat loaded at the next edge: first beat, beat after a VRF read, or successor
  always_comb begin
    w_c_addr    = w_nxt_addr;
    w_c_off     = w_nxt_off;
    w_c_total   = r_total;
    w_c_eew     = r_eew;
    w_c_strided = r_strided;
    case (r_state)
      ST_IDLE: begin
        w_c_addr    = bus.i_req_base;
        w_c_off     = '0;
        w_c_total   = w_req_total;
        w_c_eew     = bus.i_req_eew;
        w_c_strided = bus.i_req_strided;
      end
      ST_VRD: begin
        w_c_addr = r_addr;
        w_c_off  = r_off;
      end
      default: ;
    endcase
  end

  tt_vec_ldst_seq_beat_calc u_calc (
    .i_addr_lo   (w_c_addr[BEAT_LO_W-1:0]),
    .i_off       (w_c_off),
    .i_total     (w_c_total),
    .i_eew       (w_c_eew),
    .i_strided   (w_c_strided),
    .o_n         (w_calc_n),
    .o_byte_mask (w_calc_mask),
    .o_last      (w_calc_last)
  );

  always_comb begin
    w_beat           = '0;
    w_beat.lqid      = (r_state == ST_IDLE) ? bus.i_req_lqid  : r_lqid;
    w_beat.store     = (r_state == ST_IDLE) ? bus.i_req_store : r_store;
    w_beat.vreg      = ((r_state == ST_IDLE) ? bus.i_req_vreg : r_vreg0) + w_c_off[9:5];
    w_beat.addr      = w_c_addr;
    w_beat.idx       = w_c_off[IDX_W-1:0];
    w_beat.byte_mask = w_calc_mask;
    w_beat.idx_last  = w_calc_last;
    w_beat.is_128    = ~w_c_strided;
    if (r_state == ST_VRD)        w_beat.store_data = bus.i_vrf_rdata;
    else if (r_state == ST_ISSUE) w_beat.store_data = r_beat.store_data;
  end

  always_ff @(posedge i_clk) begin
    r_done         <= 1'b0;
    r_vl_zero      <= 1'b0;
    r_exc_misalign <= 1'b0;
    r_exc_illegal  <= 1'b0;
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_req_rdy   <= 1'b1;
      r_mem_vld   <= 1'b0;
      r_beat      <= '0;
      r_addr      <= '0;
      r_off       <= '0;
      r_total     <= '0;
      r_n         <= '0;
      r_stride    <= '0;
      r_eew       <= '0;
      r_strided   <= 1'b0;
      r_store     <= 1'b0;
      r_vreg0     <= '0;
      r_lqid      <= '0;
      r_vrf_raddr <= '0;
    end else if (bus.i_flush) begin
      r_state   <= ST_IDLE;
      r_req_rdy <= 1'b1;
      r_mem_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept_req) begin
          r_total   <= w_req_total;
          r_stride  <= bus.i_req_stride;
          r_eew     <= bus.i_req_eew;
          r_strided <= bus.i_req_strided;
          r_store   <= bus.i_req_store;
          r_vreg0   <= bus.i_req_vreg;
          r_lqid    <= bus.i_req_lqid;
          r_off     <= '0;
          r_addr    <= bus.i_req_base;
          r_n       <= w_calc_n;
          if (bus.i_req_vl == '0) begin
            r_done    <= 1'b1;
            r_vl_zero <= 1'b1;
          end else if (w_illegal | w_misalign) begin
            r_exc_illegal  <= w_illegal;
            r_exc_misalign <= w_misalign;
          end else if (bus.i_req_store) begin
            r_state     <= ST_VRD;
            r_req_rdy   <= 1'b0;
            r_vrf_raddr <= bus.i_req_vreg;
          end else begin
            r_state   <= ST_ISSUE;
            r_req_rdy <= 1'b0;
            r_mem_vld <= 1'b1;
            r_beat    <= w_beat;
          end
        end
        // Read data is valid during this cycle, one cycle after r_vrf_raddr updated
        ST_VRD: begin
          r_state   <= ST_ISSUE;
          r_mem_vld <= 1'b1;
          r_beat    <= w_beat;
          r_n       <= w_calc_n;
        end
        ST_ISSUE: if (w_beat_acc) begin
          if (r_beat.idx_last) begin
            r_state   <= ST_IDLE;
            r_req_rdy <= 1'b1;
            r_mem_vld <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_off  <= w_nxt_off;
            r_addr <= w_nxt_addr;
            if (r_store && (w_nxt_off[IDX_W-1:0] == '0)) begin
              r_state     <= ST_VRD;
              r_mem_vld   <= 1'b0;
              r_vrf_raddr <= r_vreg0 + w_nxt_off[9:5];
            end else begin
              r_beat <= w_beat;
              r_n    <= w_calc_n;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_req_rdy <= 1'b1;
          r_mem_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_req_rdy      = r_req_rdy;
  assign bus.o_vrf_raddr    = r_vrf_raddr;
  assign bus.o_mem_vld      = r_mem_vld;
  assign bus.o_mem_beat     = r_beat;
  assign bus.o_done         = r_done;
  assign bus.o_vl_zero      = r_vl_zero;
  assign bus.o_exc_misalign = r_exc_misalign;
  assign bus.o_exc_illegal  = r_exc_illegal;

endmodule
`default_nettype wire
